// File: rtl/seg7_scan_ctrl_if.sv
// Display-data and scan-status bundle for the 7-segment scan controller.
interface seg7_scan_ctrl_if;
    logic        ena;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [1:0]  scan_select;
    logic [7:0]  seg7;
    logic        pending;
    logic        frame_done;

    // The driver of display data and the consumer of scan outputs.
    modport master (
        output ena, load, digits_in, dp_in, blank_lz,
        input  scan_select, seg7, pending, frame_done
    );

    // The scan controller itself.
    modport slave (
        input  ena, load, digits_in, dp_in, blank_lz,
        output scan_select, seg7, pending, frame_done
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with a double-buffered
// display register. New data written while scanning waits in the shadow
// register and is copied to the active register only at a frame boundary,
// so a frame never shows a mix of old and new digits.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | display off, seg7 = 0, load writes the active data directly
// ST_SCAN | cycling digits 0..3, SCAN_DIV clocks each; load -> shadow
module seg7_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 4
) (
    input logic             clock,
    input logic             rst,
    seg7_scan_ctrl_if.slave bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [1:0]  scan_select_q, scan_select_d;
    logic [7:0]  seg7_q, seg7_d;
    logic        pending_q, pending_d;
    logic        frame_done_q, frame_done_d;
    logic [19:0] active_q, active_d;
    logic [19:0] shadow_q, shadow_d;
    logic [19:0] in_word;

    assign in_word = {bus.dp_in, bus.digits_in};

    // Segment pattern of one digit of a {dp[3:0], digits[15:0]} word,
    // with optional leading-zero blanking (dp is never blanked).
    function automatic logic [7:0] decode(input logic [19:0] data,
                                          input logic [1:0]  idx,
                                          input logic        blz);
        logic [3:0] nib;
        logic       dp;
        logic       blank;
        logic [6:0] seg;
        case (idx)
            2'd0: begin nib = data[3:0];   dp = data[16]; blank = 1'b0; end
            2'd1: begin nib = data[7:4];   dp = data[17]; blank = (data[15:4] == 12'h000); end
            2'd2: begin nib = data[11:8];  dp = data[18]; blank = (data[15:8] == 8'h00); end
            default: begin nib = data[15:12]; dp = data[19]; blank = (data[15:12] == 4'h0); end
        endcase
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        if (blz && blank) begin
            seg = 7'h00;
        end
        return {dp, seg};
    endfunction

    // Register stage with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            div_cnt_q     <= 8'd0;
            scan_select_q <= 2'd0;
            seg7_q        <= 8'h00;
            pending_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            active_q      <= 20'd0;
            shadow_q      <= 20'd0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            scan_select_q <= scan_select_d;
            seg7_q        <= seg7_d;
            pending_q     <= pending_d;
            frame_done_q  <= frame_done_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
        end
    end

    // Next-state: scan sequencing, double-buffer management and decode.
    always_comb begin
        logic [1:0] sel_next;
        state_d       = state_q;
        div_cnt_d     = div_cnt_q;
        scan_select_d = scan_select_q;
        seg7_d        = seg7_q;
        pending_d     = pending_q;
        frame_done_d  = 1'b0;
        active_d      = active_q;
        shadow_d      = shadow_q;
        sel_next      = scan_select_q + 2'd1;

        case (state_q)
            ST_IDLE: begin
                div_cnt_d = 8'd0;
                seg7_d    = 8'h00;
                pending_d = 1'b0;
                if (bus.load) begin
                    active_d = in_word;
                end
                if (bus.ena) begin
                    state_d       = ST_SCAN;
                    scan_select_d = 2'd0;
                    seg7_d        = decode(active_d, 2'd0, bus.blank_lz);
                end
            end

            default: begin
                if (!bus.ena) begin
                    // Leaving the scan: flush any waiting data so IDLE always
                    // holds the most recent write in the active register.
                    state_d   = ST_IDLE;
                    div_cnt_d = 8'd0;
                    seg7_d    = 8'h00;
                    pending_d = 1'b0;
                    if (bus.load) begin
                        active_d = in_word;
                    end else if (pending_q) begin
                        active_d = shadow_q;
                    end
                end else begin
                    if (bus.load) begin
                        shadow_d  = in_word;
                        pending_d = 1'b1;
                    end
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_d     = 8'd0;
                        scan_select_d = sel_next;
                        if (scan_select_q == 2'd3) begin
                            frame_done_d = 1'b1;
                            if (bus.load) begin
                                active_d  = in_word;
                                pending_d = 1'b0;
                            end else if (pending_q) begin
                                active_d  = shadow_q;
                                pending_d = 1'b0;
                            end
                        end
                        seg7_d = decode(active_d, sel_next, bus.blank_lz);
                    end else begin
                        div_cnt_d = div_cnt_q + 8'd1;
                    end
                end
            end
        endcase
    end

    assign bus.scan_select = scan_select_q;
    assign bus.seg7        = seg7_q;
    assign bus.pending     = pending_q;
    assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl: directed scenarios plus random traffic,
// checked cycle by cycle against a time-based reference model through a
// scoreboard queue.
module tb_seg7_scan_ctrl;

    localparam int DIV = 4;

    logic clock;
    logic rst;

    seg7_scan_ctrl_if bus ();

    seg7_scan_ctrl #(.SCAN_DIV(DIV)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] seg;
        logic       pend;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state: scanning flag and elapsed scan time.
    logic        m_scan;
    int          m_t;
    logic [1:0]  m_sel;
    logic [7:0]  m_seg;
    logic        m_pend;
    logic        m_fd;
    logic [19:0] m_act;
    logic [19:0] m_sh;
    logic        cur_blz;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    function automatic logic [7:0] ref_dec(input logic [19:0] a, input int i, input logic b);
        int  v;
        int  upper;
        int  dp;
        logic [7:0] s;
        v     = int'(a >> (4 * i)) & 15;
        upper = int'(a[15:0]) >> (4 * i);
        dp    = int'(a >> (16 + i)) & 1;
        s     = {1'b0, seg_tab[v]};
        if (b && i > 0 && upper == 0) s = 8'h00;
        if (dp != 0) s[7] = 1'b1;
        return s;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic l,
                              input logic [19:0] w, input logic b);
        exp_t x;
        if (!r) begin
            m_scan = 0; m_t = 0; m_sel = 0; m_seg = 0;
            m_pend = 0; m_fd = 0; m_act = 0; m_sh = 0;
        end else if (!m_scan) begin
            m_fd = 0;
            if (l) m_act = w;
            if (e) begin
                m_scan = 1; m_t = 0; m_sel = 0;
                m_seg = ref_dec(m_act, 0, b);
            end else begin
                m_seg = 0;
            end
        end else if (!e) begin
            m_scan = 0; m_t = 0;
            if (l) m_act = w;
            else if (m_pend) m_act = m_sh;
            m_pend = 0; m_seg = 0; m_fd = 0;
        end else begin
            m_t++;
            if (l) begin m_sh = w; m_pend = 1; end
            m_fd = ((m_t % (4 * DIV)) == 0);
            if (m_fd && m_pend) begin m_act = m_sh; m_pend = 0; end
            m_sel = 2'((m_t / DIV) % 4);
            if ((m_t % DIV) == 0) m_seg = ref_dec(m_act, int'(m_sel), b);
        end
        x.sel = m_sel; x.seg = m_seg; x.pend = m_pend; x.fd = m_fd;
        exp_q.push_back(x);
    endtask

    // One clock of stimulus: drive after negedge, model the edge, push expectation.
    task automatic step(input logic r, input logic e, input logic l,
                        input logic [15:0] d, input logic [3:0] p, input logic b);
        @(negedge clock);
        rst           = r;
        bus.ena       = e;
        bus.load      = l;
        bus.digits_in = d;
        bus.dp_in     = p;
        bus.blank_lz  = b;
        cur_blz       = b;
        @(posedge clock);
        model_step(r, e, l, {p, d}, b);
        #1;
    endtask

    // Scoreboard monitor: one expectation per clock, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("scan_select", int'(bus.scan_select), int'(e.sel));
                chk("seg7",        int'(bus.seg7),        int'(e.seg));
                chk("pending",     int'(bus.pending),     int'(e.pend));
                chk("frame_done",  int'(bus.frame_done),  int'(e.fd));
            end
        end
    end

    initial begin
        rst = 1'b0; bus.ena = 1'b0; bus.load = 1'b0;
        bus.digits_in = 16'h0; bus.dp_in = 4'h0; bus.blank_lz = 1'b0;
        cur_blz = 1'b0;
        m_scan = 0; m_t = 0; m_sel = 0; m_seg = 0; m_pend = 0; m_fd = 0; m_act = 0; m_sh = 0;

        // Reset held with ena=1, then release: digit 0 of zero data.
        step(0, 1, 0, 16'h0, 4'h0, 0);
        chk("reset_seg7", int'(bus.seg7), 0);
        chk("reset_pending", int'(bus.pending), 0);
        step(0, 1, 1, 16'hFFFF, 4'hF, 0);
        step(1, 1, 0, 16'h0, 4'h0, 0);
        chk("release_seg7", int'(bus.seg7), 8'h3F);
        chk("release_sel", int'(bus.scan_select), 0);
        step(1, 0, 0, 16'h0, 4'h0, 0);

        // IDLE load 1234, then scan two frames.
        step(1, 0, 1, 16'h1234, 4'h0, 0);
        for (int k = 0; k < 34; k++) step(1, 1, 0, 16'h0, 4'h0, 0);

        // Load ABCD while digit 1 is shown.
        for (int k = 0; k < 64 && m_sel != 2'd1; k++) step(1, 1, 0, 16'h0, 4'h0, 0);
        chk("reach_sel1", int'(bus.scan_select), 1);
        step(1, 1, 1, 16'hABCD, 4'h0, 0);
        chk("abcd_pending", int'(bus.pending), 1);
        for (int k = 0; k < 24; k++) step(1, 1, 0, 16'h0, 4'h0, 0);

        // Leading-zero blanking on 0050 with dp on digit 3.
        step(1, 0, 0, 16'h0, 4'h0, 1);
        step(1, 0, 1, 16'h0050, 4'b1000, 1);
        for (int k = 0; k < 20; k++) step(1, 1, 0, 16'h0, 4'h0, 1);

        // Drop ena at digit 2 with data pending, then re-enable.
        for (int k = 0; k < 64 && m_sel != 2'd0; k++) step(1, 1, 0, 16'h0, 4'h0, 0);
        step(1, 1, 1, 16'h9876, 4'b0101, 0);
        for (int k = 0; k < 64 && m_sel != 2'd2; k++) step(1, 1, 0, 16'h0, 4'h0, 0);
        step(1, 0, 0, 16'h0, 4'h0, 0);
        chk("drop_seg7", int'(bus.seg7), 0);
        chk("drop_sel", int'(bus.scan_select), 2);
        chk("drop_pending", int'(bus.pending), 0);
        step(1, 0, 0, 16'h0, 4'h0, 0);
        for (int k = 0; k < 18; k++) step(1, 1, 0, 16'h0, 4'h0, 0);

        // Load coincident with the 3->0 wrap.
        for (int k = 0; k < 64 && (m_t % (4 * DIV)) != (4 * DIV - 1); k++)
            step(1, 1, 0, 16'h0, 4'h0, 0);
        step(1, 1, 1, 16'h000F, 4'h0, 0);
        chk("wrapload_seg7", int'(bus.seg7), 8'h71);
        chk("wrapload_fd", int'(bus.frame_done), 1);
        chk("wrapload_pending", int'(bus.pending), 0);
        for (int k = 0; k < 8; k++) step(1, 1, 0, 16'h0, 4'h0, 0);

        // Randomized traffic including mid-frame resets and ena drops.
        for (int k = 0; k < 2000; k++) begin
            logic r, e, l, b;
            logic [15:0] d;
            r = ($urandom_range(0, 99) != 0);
            e = ($urandom_range(0, 99) >= 4);
            l = ($urandom_range(0, 9) == 0);
            d = ($urandom_range(0, 1) != 0) ? 16'($urandom) : (16'($urandom) & 16'h00FF);
            b = ($urandom_range(0, 19) == 0) ? ~cur_blz : cur_blz;
            step(r, e, l, d, 4'($urandom), b);
        end

        @(negedge clock);
        @(negedge clock);
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
